// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller over a dual-port RAM with a 2-entry registered output buffer
module ram_fifo_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              clear,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              ram_wr_en,
  output logic              ram_wr_we,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_avail_q, ram_avail_d, count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic              push, pop, issue;
  logic [2:0]        occ;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign s_ready = !full && !clear;
  assign push    = s_valid && s_ready && sys_rst_n;
  assign m_valid = (buf_cnt_q != 2'd0);
  assign m_data  = buf_q[0];
  assign pop     = m_valid && m_ready;

  // Slots the buffer will hold after this edge; a read issued now lands one edge later.
  assign occ   = {1'b0, buf_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = (ram_avail_q != '0) && (occ < 3'd2) && !clear;

  assign ram_wr_en   = push;
  assign ram_wr_we   = push;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_wr_data = s_data;
  assign ram_rd_en   = issue;
  assign ram_rd_addr = rd_ptr_q;
  assign count       = count_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d    = rd_ptr_q + ADDR_W'(issue);
    ram_avail_d = ram_avail_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(issue);
    inflight_d  = issue;
    count_d     = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    if (pop) begin
      buf_d[0]  = buf_q[1];
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    if (inflight_q) begin
      buf_d[buf_cnt_d[0]] = ram_rd_data;
      buf_cnt_d = buf_cnt_d + 2'd1;
    end
    // Flush drops the in-flight read so its data never reaches the buffer.
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_avail_d = '0;
      inflight_d  = 1'b0;
      count_d     = '0;
      buf_cnt_d   = 2'd0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_avail_q <= '0;
      inflight_q  <= 1'b0;
      count_q     <= '0;
      buf_cnt_q   <= 2'd0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_avail_q <= ram_avail_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      buf_cnt_q   <= buf_cnt_d;
      buf_q[0]    <= buf_d[0];
      buf_q[1]    <= buf_d[1];
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - randomized and directed bench for ram_fifo_ctrl against a queue model
module tb_ram_fifo_ctrl;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       clear = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready, m_valid, full, empty;
  logic [7:0] m_data, ram_wr_data, ram_rd_data;
  logic       ram_wr_en, ram_wr_we, ram_rd_en;
  logic [5:0] ram_wr_addr, ram_rd_addr;
  logic [6:0] count;

  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  ram_fifo_ctrl #(.ADDR_W(6), .DATA_W(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_wr_en(ram_wr_en), .ram_wr_we(ram_wr_we), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .count(count), .full(full), .empty(empty)
  );

  logic [7:0] mem [64];
  always @(posedge sys_clk) begin
    if (ram_wr_en && ram_wr_we) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: FIFO contents as a queue, addresses from push/issue counts since the last flush.
  logic [7:0] q [$];
  int wr_n, pushed, issued, popped;
  bit mpush, mpop, exp_full;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      q.delete(); wr_n = 0; pushed = 0; issued = 0; popped = 0;
    end else begin
      exp_full = (q.size() == 64);
      chk("count", int'(count), q.size());
      chk("full", int'(full), int'(exp_full));
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("s_ready", int'(s_ready), int'(!exp_full && !clear));
      mpush = s_valid && !exp_full && !clear;
      chk("wr_en", int'(ram_wr_en), int'(mpush));
      chk("wr_we", int'(ram_wr_we), int'(mpush));
      if (mpush) begin
        chk("wr_addr", int'(ram_wr_addr), wr_n % 64);
        chk("wr_data", int'(ram_wr_data), int'(s_data));
      end
      if (ram_rd_en) begin
        chk("rd_in_clear", int'(clear), 0);
        chk("rd_avail", int'(issued < pushed), 1);
        chk("rd_addr", int'(ram_rd_addr), issued % 64);
      end
      chk("occupancy", int'((issued - popped) <= 2), 1);
      if (m_valid) begin
        chk("m_valid_nonempty", int'(q.size() != 0), 1);
        if (q.size() != 0) chk("m_data", int'(m_data), int'(q[0]));
      end
      mpop = m_valid && m_ready && (q.size() != 0);
      if (clear) begin
        q.delete(); wr_n = 0; pushed = 0; issued = 0; popped = 0;
      end else begin
        if (mpush) begin q.push_back(s_data); wr_n++; pushed++; end
        if (ram_rd_en) issued++;
        if (mpop) begin void'(q.pop_front()); popped++; end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_single(input logic [7:0] d);
    s_valid = 1'b1; s_data = d; m_ready = 1'b1;
    @(negedge sys_clk);
    chk("single_wr_en", int'(ram_wr_en), 1);
    chk("single_wr_addr", int'(ram_wr_addr), 0);
    tick(); s_valid = 1'b0;
    @(negedge sys_clk);
    chk("single_rd_en", int'(ram_rd_en), 1);
    chk("single_rd_addr", int'(ram_rd_addr), 0);
    chk("single_count", int'(count), 1);
    tick(); @(negedge sys_clk);
    chk("single_mv_e1", int'(m_valid), 0);
    tick(); @(negedge sys_clk);
    chk("single_mv_e2", int'(m_valid), 1);
    chk("single_data", int'(m_data), int'(d));
    tick(); @(negedge sys_clk);
    chk("single_empty", int'(empty), 1);
    chk("single_mv_after", int'(m_valid), 0);
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    s_valid = 1'b0; m_ready = 1'b1; n = 0;
    while (!empty && n < 200) begin tick(); n++; end
    chk(name, int'(empty), 1);
    tick(); tick();
  endtask

  initial begin
    int k, n, gaps, cchg, cnt0;
    bit prev63, wrapped;
    #3;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_rd_en", int'(ram_rd_en), 0);
    @(posedge sys_clk); @(posedge sys_clk); #2 sys_rst_n = 1'b1;
    tick();

    run_single(8'hA5);

    // Fill to full with the consumer stalled, then drain in order.
    m_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin s_valid = 1'b1; s_data = 8'(i); tick(); end
    s_data = 8'h40;
    @(negedge sys_clk);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 64);
    chk("fill_s_ready", int'(s_ready), 0);
    chk("fill_no_write", int'(ram_wr_en), 0);
    tick(); m_ready = 1'b1;
    @(negedge sys_clk);
    chk("popfull_no_write", int'(ram_wr_en), 0);
    chk("popfull_data", int'(m_data), 0);
    tick(); s_valid = 1'b0;
    @(negedge sys_clk);
    chk("popfull_s_ready", int'(s_ready), 1);
    chk("popfull_count", int'(count), 63);
    k = 1; n = 0;
    while (k < 64 && n < 400) begin
      if (m_valid) begin chk("drain_order", int'(m_data), k); k++; end
      tick(); @(negedge sys_clk); n++;
    end
    chk("drain_all", k, 64);
    tick();
    drain("fill_drained");

    // Streaming at one word per cycle.
    gaps = 0; cchg = 0; cnt0 = 0; prev63 = 0; wrapped = 0;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      s_data = 8'(i);
      @(negedge sys_clk);
      if (i >= 3 && !m_valid) gaps++;
      if (i == 5) cnt0 = int'(count);
      if (i > 5 && int'(count) != cnt0) cchg++;
      if (ram_wr_en) begin
        if (prev63 && ram_wr_addr == 6'd0) wrapped = 1;
        prev63 = (ram_wr_addr == 6'd63);
      end
      tick();
    end
    chk("stream_gaps", gaps, 0);
    chk("stream_count", cnt0, 3);
    chk("stream_count_const", cchg, 0);
    chk("stream_wrap", int'(wrapped), 1);
    drain("stream_drained");

    // Random consumer backpressure during a continuous push.
    for (int i = 0; i < 300; i++) begin
      s_valid = 1'b1; s_data = 8'($urandom); m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain("bp_drained");

    // Flush while a read is in flight.
    m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h11;
    tick(); s_valid = 1'b0;
    @(negedge sys_clk);
    chk("clr_issue", int'(ram_rd_en), 1);
    tick(); clear = 1'b1;
    @(negedge sys_clk);
    chk("clr_rd_en", int'(ram_rd_en), 0);
    chk("clr_wr_en", int'(ram_wr_en), 0);
    tick(); clear = 1'b0;
    @(negedge sys_clk);
    chk("clr_count", int'(count), 0);
    chk("clr_m_valid", int'(m_valid), 0);
    tick(); @(negedge sys_clk);
    chk("clr_no_stale", int'(m_valid), 0);
    tick();
    run_single(8'h3C);

    // Asynchronous reset with ten words held.
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin s_valid = 1'b1; s_data = 8'(8'h80 + i); tick(); end
    s_valid = 1'b0;
    tick();
    chk("pre_rst_count", int'(count), 10);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_full", int'(full), 0);
    chk("arst_m_valid", int'(m_valid), 0);
    chk("arst_m_data", int'(m_data), 0);
    chk("arst_s_ready", int'(s_ready), 1);
    chk("arst_wr_en", int'(ram_wr_en), 0);
    chk("arst_rd_en", int'(ram_rd_en), 0);
    @(negedge sys_clk); @(posedge sys_clk); #2 sys_rst_n = 1'b1;
    tick();
    run_single(8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning the RAM address width, so DEPTH = 2**ADDR_W (64 by default).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the RAM data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports in this order:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous reset, active low
REQ-004 The block SHALL have the following remaining ports:
- clear  in  1  synchronous flush
- s_valid  in  1  producer word valid
- s_ready  out  1  controller can accept a word
- s_data  in  DATA_W  producer word
- m_valid  out  1  consumer word valid
- m_ready  in  1  consumer takes the word
- m_data  out  DATA_W  consumer word
- ram_wr_en  out  1  RAM port A enable
- ram_wr_we  out  1  RAM port A write enable
- ram_wr_addr  out  ADDR_W  port A address
- ram_wr_data  out  DATA_W  port A write data
- ram_rd_en  out  1  RAM port B enable
- ram_rd_addr  out  ADDR_W  port B address
- ram_rd_data  in  DATA_W  port B read data, valid 1 cycle after ram_rd_en
- count  out  ADDR_W+1  total words held
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Function
REQ-005 Push SHALL occur on a rising edge with s_valid && s_ready; s_ready SHALL equal !full && !clear, with no combinational path from m_ready.
REQ-006 In a push cycle, ram_wr_en and ram_wr_we SHALL be 1, ram_wr_addr SHALL be wr_ptr and ram_wr_data SHALL be s_data, all combinationally; otherwise both enables SHALL be 0.
REQ-007 wr_ptr and rd_ptr SHALL increment modulo DEPTH, with wrap from DEPTH-1 to 0.
REQ-008 A pushed word SHALL become readable from RAM in the cycle after its push edge; ram_avail SHALL count words written and not yet issued for read.
REQ-009 The block SHALL keep a 2-entry output buffer, plus at most one read in flight.
REQ-010 A read SHALL issue (ram_rd_en=1, ram_rd_addr=rd_ptr) when ram_avail>0 && (buf_cnt + inflight − pop_this_cycle) < 2 && !clear.
- rd_ptr SHALL advance on each issue.
REQ-011 ram_rd_data SHALL be written into the output buffer on the edge after the issue cycle.
REQ-012 m_valid SHALL be 1 when buf_cnt>0, and m_data SHALL be the oldest buffer entry.
- m_data SHALL come from a register, never directly from ram_rd_data.
REQ-013 Pop SHALL occur on m_valid && m_ready.
REQ-014 Order SHALL be strict FIFO.
REQ-015 With empty FIFO and m_ready=1, a word pushed on edge E0 SHALL be issued in the cycle after E0, and SHALL appear with m_valid=1 after edge E2.
REQ-016 Sustained throughput SHALL be 1 word/cycle when s_valid and m_ready are held high.
REQ-017 count SHALL update as follows:
- +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- count SHALL cover RAM, in-flight and buffer words.
REQ-018 Boundary conditions SHALL behave as follows:
- s_valid while full: ignored, no RAM write.
- m_ready while !m_valid: ignored.
- pop while full: frees a slot, push is accepted no earlier than the next cycle.
REQ-019 clear=1 SHALL have priority over everything on that edge:
- pointers, ram_avail, buf_cnt and count SHALL go to 0.
- an in-flight read SHALL be discarded and its data not captured.
- ram_wr_en, ram_wr_we and ram_rd_en SHALL be 0 in the clear cycle.
- m_valid SHALL be 0 after the edge.

Reset
REQ-020 While sys_rst_n=0, the block SHALL asynchronously set:
- all pointers, counters and inflight to 0, and the buffer to empty.
- m_valid=0, m_data=0, count=0, empty=1, full=0.
- RAM enables 0.
- s_ready=1 (the combinational !full, with clear=0).
REQ-021 Reset mid-operation SHALL discard all contents.
- The first push after release SHALL use ram_wr_addr=0.
- The first read after release SHALL use ram_rd_addr=0.

Verification
REQ-022 Single word: push 0xA5 at E0 with m_ready=1 -> ram_wr_addr=0 in the push cycle, ram_rd_en in the next cycle, m_valid=1 with m_data=0xA5 after E2, empty=1 after pop.
REQ-023 Fill: push 0..63 with m_ready=0 -> full=1, count=64, s_ready=0; the 65th s_valid causes no RAM write; drain yields 0..63 in order.
REQ-024 Streaming: s_valid=m_ready=1 for 200 cycles with an incrementing pattern -> one pop per cycle after the 2-cycle latency, no gaps, addresses wrap 63->0, count stays constant.
REQ-025 Backpressure: toggle m_ready randomly at a 50% duty during a continuous push -> no loss or duplication, buffer never exceeds 2 entries, at most 1 read in flight.
REQ-026 Clear with a read in flight -> the next edge gives count=0 and m_valid=0, stale ram_rd_data is not output, and the next push uses address 0.
REQ-027 Async reset asserted with count=10 -> outputs take reset values immediately; after release, behaviour matches REQ-022.
